tpg_clocked_video_source: RTL

- Generates a complete clocked-video stream (data, datavalid, h/v sync, field, locked) with programmable progressive timing and a selectable test pattern.
- It is the transmit end of the clocked-video conduit that the CTI input consumes. Its outputs wire directly to the vid_* inputs of the clocked-video-in interface.
- Used for loopback bring-up of the capture, SDRAM frame-buffer and CVO path without an external video source.

---
 rtl/tpg_pkg.sv | 26 ++
 rtl/tpg_timing_gen.sv | 70 +++++++
 rtl/tpg_clocked_video_source.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tpg_pkg.sv
// Shared definitions for the clocked-video test pattern generator.
//   CNT_W       : width of the h/v position counters
//   PAT_*       : pattern_sel codes
//   BAR_COLORS  : the eight colour-bar values, left to right, packed {R,G,B}
//   state_t     : run-control FSM states
package tpg_pkg;

  localparam int CNT_W = 16;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  localparam logic [23:0] BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/tpg_timing_gen.sv
// Horizontal/vertical position counters and raster decode.
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   run         : counters advance when high, are held at 0 when low
//   h_cnt/v_cnt : current raster position (line order active, FP, sync, BP)
//   active      : position is inside the active picture
//   hs/vs       : position is inside the horizontal/vertical sync region
//   first_pix   : position is (0,0)
//   line_last   : position is the last pixel of a line
//   frame_last  : position is the last pixel of a frame
module tpg_timing_gen
  import tpg_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs,
  output logic             vs,
  output logic             first_pix,
  output logic             line_last,
  output logic             frame_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_last) begin
      h_cnt <= '0;
      v_cnt <= frame_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign line_last  = (h_cnt == H_LAST_C);
  assign frame_last = line_last && (v_cnt == V_LAST_C);
  assign active     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs         = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
  // Depends on v_cnt only, so it can change only where h_cnt wraps to 0.
  assign vs         = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
  assign first_pix  = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/tpg_clocked_video_source.sv
// Clocked-video test pattern source: programmable progressive raster with
// colour bars, grey ramp, checkerboard or solid colour, feeding the vid_*
// inputs of a clocked-video-in interface.
//   clk_clk, reset_reset_n : pixel clock, asynchronous active-low reset
//   enable                 : run request; dropping it finishes the frame first
//   pattern_sel, solid_rgb : pattern choice, sampled once per frame
//   vid_*                  : registered clocked-video stream
//   frame_start            : pulse on the first active pixel of each frame
// H_ACTIVE must be at least 8 so that every colour bar is non-empty.
module tpg_clocked_video_source
  import tpg_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] vid_data,
  output logic        vid_datavalid,
  output logic        vid_h_sync,
  output logic        vid_v_sync,
  output logic        vid_f,
  output logic        vid_locked,
  output logic        frame_start
);

  localparam int               BAR_W      = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] BAR_LAST_C = CNT_W'(BAR_W - 1);
  localparam logic             HS_ON      = (HS_POL != 0);
  localparam logic             VS_ON      = (VS_POL != 0);

  state_t           state;
  logic             locked_q;
  logic             run_p0;
  logic [CNT_W-1:0] h_cnt_p0;
  logic [CNT_W-1:0] v_cnt_p0;
  logic             active_p0;
  logic             hs_p0;
  logic             vs_p0;
  logic             first_p0;
  logic             line_last_p0;
  logic             frame_last_p0;
  logic [CNT_W-1:0] bar_sub_p0;
  logic [2:0]       bar_idx_p0;
  logic [1:0]       sel_shadow;
  logic [23:0]      rgb_shadow;
  logic [1:0]       sel_eff;
  logic [23:0]      rgb_eff;
  logic [23:0]      pix_p0;
  logic [23:0]      data_p1;
  logic             vld_p1;
  logic             hs_p1;
  logic             vs_p1;
  logic             fs_p1;
  logic             unused_cnt_bits;

  assign run_p0 = (state != IDLE);

  tpg_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .run        (run_p0),
    .h_cnt      (h_cnt_p0),
    .v_cnt      (v_cnt_p0),
    .active     (active_p0),
    .hs         (hs_p0),
    .vs         (vs_p0),
    .first_pix  (first_p0),
    .line_last  (line_last_p0),
    .frame_last (frame_last_p0)
  );

  // Only the low bits feed the ramp/checker patterns.
  assign unused_cnt_bits = ^{h_cnt_p0[CNT_W-1:8], v_cnt_p0[CNT_W-1:5], v_cnt_p0[3:0]};

  // Run control. Leaving RUN only ends the stream at a frame boundary, so
  // the downstream capture never sees a truncated frame.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      locked_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (first_p0) locked_q <= 1'b1;
          if (!enable)  state    <= DRAIN;
        end
        DRAIN: begin
          if (first_p0) locked_q <= 1'b1;
          if (enable) begin
            state <= RUN;
          end else if (frame_last_p0) begin
            state    <= IDLE;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Bar position tracked incrementally so no divider is needed; the index
  // saturates so remainder pixels past the eighth bar stay black.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bar_sub_p0 <= '0;
      bar_idx_p0 <= '0;
    end else if (!run_p0 || line_last_p0) begin
      bar_sub_p0 <= '0;
      bar_idx_p0 <= '0;
    end else if (bar_sub_p0 == BAR_LAST_C) begin
      bar_sub_p0 <= '0;
      if (bar_idx_p0 != 3'd7) bar_idx_p0 <= bar_idx_p0 + 3'd1;
    end else begin
      bar_sub_p0 <= bar_sub_p0 + 1'b1;
    end
  end

  // Pattern controls are frozen for a whole frame.
  always_ff @(posedge clk_clk) begin
    if (run_p0 && first_p0) begin
      sel_shadow <= pattern_sel;
      rgb_shadow <= solid_rgb;
    end
  end

  // The first pixel of a frame uses the live inputs, since the shadow
  // registers are loaded on that same edge.
  always_comb begin
    sel_eff = first_p0 ? pattern_sel : sel_shadow;
    rgb_eff = first_p0 ? solid_rgb : rgb_shadow;
    pix_p0  = '0;
    case (sel_eff)
      PAT_BARS:  pix_p0 = BAR_COLORS[bar_idx_p0];
      PAT_RAMP:  pix_p0 = {3{h_cnt_p0[7:0]}};
      PAT_CHECK: pix_p0 = (h_cnt_p0[4] ^ v_cnt_p0[4]) ? 24'hFFFFFF : 24'h000000;
      default:   pix_p0 = rgb_eff;
    endcase
  end

  // ---- stage p0 -> p1: output register ----
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      hs_p1   <= ~HS_ON;
      vs_p1   <= ~VS_ON;
      fs_p1   <= 1'b0;
    end else begin
      vld_p1  <= run_p0 && active_p0;
      data_p1 <= (run_p0 && active_p0) ? pix_p0 : 24'h000000;
      hs_p1   <= (run_p0 && hs_p0) ? HS_ON : ~HS_ON;
      vs_p1   <= (run_p0 && vs_p0) ? VS_ON : ~VS_ON;
      fs_p1   <= run_p0 && active_p0 && first_p0;
    end
  end

  assign vid_data      = data_p1;
  assign vid_datavalid = vld_p1;
  assign vid_h_sync    = hs_p1;
  assign vid_v_sync    = vs_p1;
  assign vid_f         = 1'b0;
  assign vid_locked    = locked_q;
  assign frame_start   = fs_p1;

endmodule
